// File: rtl/mem_access_unit.sv
// Byte/half/word load-store initiator for a word-addressed memory; sub-word stores use read-modify-write.
// Optional macro MISALIGN_TRAP_EN: reject misaligned half/word accesses instead of ignoring the low address bits.
module mem_access_unit #(
  parameter int DEPTH_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Request handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and there is no backpressure on the one-cycle response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        misalign;
  logic        req_err;

  assign dbg_state = state_q;

  always_comb begin
    misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    req_err = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) || (req_size == 2'b11) || misalign;
  end

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_ext = {{24{~uns & b[7]}}, b};
      2'b01:   load_ext = {{16{~uns & h[15]}}, h};
      default: load_ext = word;
    endcase
  endfunction

  // Without the misalign trap, halves use only lane[1] and words ignore both lane bits.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    store_merge = old;
    case (size)
      2'b00:   store_merge[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01:   store_merge[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_merge = wdata;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 32'h0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_write && (req_size == 2'b10)) begin
              state_q   <= WRITE;
              mem_write <= 1'b1;
              mem_addr  <= {2'b00, req_addr[31:2]};
              mem_wdata <= req_wdata;
            end else begin
              state_q  <= READ;
              mem_read <= 1'b1;
              mem_addr <= {2'b00, req_addr[31:2]};
            end
          end
        end
        READ: begin
          mem_read <= 1'b0;
          if (write_q) begin
            state_q   <= WRITE;
            mem_write <= 1'b1;
            mem_wdata <= store_merge(mem_rdata, wdata_q, size_q, lane_q);
          end else begin
            state_q    <= RESP;
            mem_addr   <= 32'h0;
            resp_valid <= 1'b1;
            resp_rdata <= load_ext(mem_rdata, size_q, lane_q, uns_q);
          end
        end
        WRITE: begin
          state_q    <= RESP;
          mem_write  <= 1'b0;
          mem_addr   <= 32'h0;
          mem_wdata  <= 32'h0;
          resp_valid <= 1'b1;
          resp_rdata <= 32'h0;
        end
        RESP: begin
          state_q    <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic against a byte-array memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  mem_access_unit #(.DEPTH_WORDS(128)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [128];
  logic        pre_we;
  logic [6:0]  pre_idx;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[6:0]] <= mem_wdata;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end
  assign mem_rdata = mem[mem_addr[6:0]];

  // ---------------- reference model (byte memory) ----------------
  logic [7:0] ref_b [512];
  int checks = 0;
  int errors = 0;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
    bit e;
    e = ((a >> 2) >= 128) || (sz == 2'b11);
`ifdef MISALIGN_TRAP_EN
    if (sz != 2'b11 && (a % nbytes(sz)) != 0) e = 1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int n;
    int base;
    longint v;
    n = nbytes(sz);
    base = int'(a) - (int'(a) % n);
    v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_b[base + i]);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    int base;
    n = nbytes(sz);
    base = int'(a) - (int'(a) % n);
    for (int i = 0; i < n; i++) ref_b[base + i] = wd[8 * i +: 8];
  endfunction

  function automatic logic [31:0] model_word(input int idx);
    return {ref_b[4 * idx + 3], ref_b[4 * idx + 2], ref_b[4 * idx + 1], ref_b[4 * idx]};
  endfunction

  // ---------------- driver tasks ----------------
  int          r_lat;
  int          r_resp_cyc;
  bit          r_done;
  bit          r_rd;
  bit          r_wr;
  bit          r_after_ok;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_waddr;

  task automatic preload(input int idx, input logic [31:0] d);
    pre_we = 1'b1;
    pre_idx = idx[6:0];
    pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[4 * idx + i] = d[8 * i +: 8];
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    r_lat = 0; r_done = 0; r_rd = 0; r_wr = 0; r_err = 1'b0; r_rdata = 32'h0; r_waddr = 32'h0;
    r_resp_cyc = 0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    for (int i = 1; i <= 8 && !r_done; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      r_lat = i;
      if (mem_read) r_rd = 1;
      if (mem_write) begin r_wr = 1; r_waddr = mem_addr; end
      if (resp_valid) begin r_done = 1; r_rdata = resp_rdata; r_err = resp_err; r_resp_cyc = cyc; end
    end
    @(negedge clk);
    r_after_ok = !resp_valid && req_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] obs;
    reset = 1'b1;
    #1;
    obs = {req_ready, resp_valid, resp_err, mem_write, mem_read, |resp_rdata, |mem_addr, |mem_wdata};
    checks++; if (obs !== 8'b1000_0000) begin errors++; $display("FAIL reset_outputs got %b want %b", obs, 8'b1000_0000); end
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    @(negedge clk);
    obs = {req_ready, resp_valid, resp_err, mem_write, mem_read, |resp_rdata, |mem_addr, |mem_wdata};
    checks++; if (obs !== 8'b1000_0000) begin errors++; $display("FAIL reset_held_valid got %b want %b", obs, 8'b1000_0000); end
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_word();
    preload(4, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    model_store(32'h10, 2'b10, 32'hDEADBEEF);
    checks++; if (r_lat !== 2 || !r_done) begin errors++; $display("FAIL word_store_lat got %0d want 2", r_lat); end
    checks++; if (r_waddr !== 32'd4 || !r_wr) begin errors++; $display("FAIL word_store_addr got %0d want 4", r_waddr); end
    checks++; if (r_rd !== 1'b0) begin errors++; $display("FAIL word_store_noread got %b want 0", r_rd); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_mem got %h want deadbeef", mem[4]); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (r_rdata !== 32'hDEADBEEF || r_err !== 1'b0) begin errors++; $display("FAIL word_load_data got %h want deadbeef", r_rdata); end
    checks++; if (r_lat !== 2 || !r_done) begin errors++; $display("FAIL word_load_lat got %0d want 2", r_lat); end
  endtask

  task automatic test_byte();
    preload(4, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA);
    model_store(32'h11, 2'b00, 32'h000000AA);
    checks++; if (r_lat !== 3 || !r_done) begin errors++; $display("FAIL byte_store_lat got %0d want 3", r_lat); end
    checks++; if (mem[4] !== 32'h1122AA44) begin errors++; $display("FAIL byte_store_mem got %h want 1122aa44", mem[4]); end
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    checks++; if (r_rdata !== 32'hFFFFFFAA) begin errors++; $display("FAIL byte_load_signed got %h want ffffffaa", r_rdata); end
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    checks++; if (r_rdata !== 32'h000000AA) begin errors++; $display("FAIL byte_load_unsigned got %h want 000000aa", r_rdata); end
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    checks++; if (r_rdata !== 32'h00000011) begin errors++; $display("FAIL byte_load_lane3 got %h want 00000011", r_rdata); end
  endtask

  task automatic test_half();
    preload(4, 32'h11223344);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF);
    model_store(32'h12, 2'b01, 32'h0000BEEF);
    checks++; if (r_lat !== 3 || !r_done) begin errors++; $display("FAIL half_store_lat got %0d want 3", r_lat); end
    checks++; if (mem[4] !== 32'hBEEF3344) begin errors++; $display("FAIL half_store_mem got %h want beef3344", mem[4]); end
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    checks++; if (r_rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL half_load_signed got %h want ffffbeef", r_rdata); end
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    checks++; if (r_rdata !== 32'h00003344) begin errors++; $display("FAIL half_load_low got %h want 00003344", r_rdata); end
  endtask

  task automatic test_misalign();
    preload(4, 32'h11223344);
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
`ifdef MISALIGN_TRAP_EN
    checks++; if (r_err !== 1'b1 || r_lat !== 1) begin errors++; $display("FAIL misalign_trap err=%b lat=%0d want err=1 lat=1", r_err, r_lat); end
    checks++; if (r_rd !== 1'b0 || r_rdata !== 32'h0) begin errors++; $display("FAIL misalign_trap_noread rd=%b data=%h want 0", r_rd, r_rdata); end
`else
    checks++; if (r_rdata !== 32'h11223344 || r_err !== 1'b0) begin errors++; $display("FAIL misalign_load got %h want 11223344", r_rdata); end
    checks++; if (r_lat !== 2) begin errors++; $display("FAIL misalign_load_lat got %0d want 2", r_lat); end
`endif
  endtask

  task automatic test_errors();
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    checks++; if (r_err !== 1'b1 || r_lat !== 1 || r_rdata !== 32'h0) begin errors++; $display("FAIL range_err err=%b lat=%0d data=%h want 1/1/0", r_err, r_lat, r_rdata); end
    checks++; if (r_rd || r_wr) begin errors++; $display("FAIL range_err_strobes rd=%b wr=%b want 0", r_rd, r_wr); end
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    checks++; if (r_err !== 1'b1 || r_rd) begin errors++; $display("FAIL size_err err=%b rd=%b want 1/0", r_err, r_rd); end
    do_req(1'b1, 2'b00, 1'b0, 32'h1FF, 32'h5A);
    model_store(32'h1FF, 2'b00, 32'h5A);
    checks++; if (r_err !== 1'b0 || mem[127] !== model_word(127)) begin errors++; $display("FAIL last_byte_store got %h want %h", mem[127], model_word(127)); end
  endtask

  task automatic test_back_to_back();
    int prev;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    prev = r_resp_cyc;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 2'b10, 1'b0, 32'h24 + 4 * i, 32'h0);
      checks++; if (r_resp_cyc - prev !== 3 || !r_after_ok) begin errors++; $display("FAIL b2b_spacing got %0d want 3", r_resp_cyc - prev); end
      prev = r_resp_cyc;
    end
  endtask

  task automatic test_reset_mid();
    bit saw_resp;
    logic [4:0] obs;
    preload(4, 32'h11223344);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rmw_read_phase got %b want 1", mem_read); end
    #2 reset = 1'b1;
    #1;
    obs = {mem_read, mem_write, |mem_addr, |mem_wdata, resp_valid};
    checks++; if (obs !== 5'b0) begin errors++; $display("FAIL reset_mid_async got %b want 00000", obs); end
    saw_resp = 0;
    repeat (3) begin @(negedge clk); if (resp_valid) saw_resp = 1; end
    reset = 1'b0;
    @(negedge clk);
    if (resp_valid) saw_resp = 1;
    checks++; if (saw_resp || req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_resp resp=%b ready=%b want 0/1", saw_resp, req_ready); end
    checks++; if (mem[4] !== 32'h11223344) begin errors++; $display("FAIL reset_mid_mem got %h want 11223344", mem[4]); end
  endtask

  task automatic test_random();
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_data;
    bit          e;
    int          exp_lat;
    for (int t = 0; t < 120; t++) begin
      w = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(512, 4095) : $urandom_range(0, 511);
      wd = $urandom();
      e = model_err(a, sz);
      exp_data = (e || w) ? 32'h0 : model_load(a, sz, u);
      exp_lat = e ? 1 : (!w ? 2 : (sz == 2'b10 ? 2 : 3));
      do_req(w, sz, u, a, wd);
      if (!e && w) model_store(a, sz, wd);
      checks++; if (!r_done || r_lat !== exp_lat) begin errors++; $display("FAIL rnd_lat a=%h sz=%0d w=%b got %0d want %0d", a, sz, w, r_lat, exp_lat); end
      checks++; if (r_err !== e || r_rdata !== exp_data) begin errors++; $display("FAIL rnd_resp a=%h sz=%0d w=%b u=%b got %b/%h want %b/%h", a, sz, w, u, r_err, r_rdata, e, exp_data); end
      checks++; if (r_rd !== (!e && (!w || sz != 2'b10)) || r_wr !== (!e && w)) begin errors++; $display("FAIL rnd_strobes a=%h got rd=%b wr=%b", a, r_rd, r_wr); end
      checks++; if (!r_after_ok) begin errors++; $display("FAIL rnd_pulse a=%h got pulse_or_busy want idle", a); end
      if (!e && w) begin
        checks++; if (r_waddr !== (a >> 2) || mem[a[8:2]] !== model_word(int'(a[8:2]))) begin errors++; $display("FAIL rnd_store a=%h got %h want %h", a, mem[a[8:2]], model_word(int'(a[8:2]))); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; pre_we = 1'b0; pre_idx = 7'h0; pre_data = 32'h0;
    test_reset();
    for (int i = 0; i < 128; i++) preload(i, $urandom());
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
